// File: rtl/uart_rx_edge_bit_sampler.sv
// uart_rx_edge_bit_sampler: oversampling edge/bit counters and 3-sample majority bit recovery
module uart_rx_edge_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  cnt_enable,
    input  logic                  data_samp_en,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  last_edge_flag,
    output logic                  sample_done,
    output logic                  sampled_bit
);
    localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);
    logic [PRESCALE_W-1:0] p_q, h, last_e, h_m1, h_p1;
    logic [1:0] s;
    logic samp_en;
    assign h       = p_q >> 1;
    assign h_m1    = h - ONE;
    assign h_p1    = h + ONE;
    assign last_e  = p_q - ONE;
    assign samp_en = cnt_enable & data_samp_en;
    assign last_edge_flag = rst & cnt_enable & (edge_cnt == last_e);
    // prescale is only latched while stopped so a frame never changes bit length mid-way
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            p_q      <= PRESCALE_W'(8);
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (!cnt_enable) begin
            p_q      <= prescale;
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (edge_cnt == last_e) begin
            edge_cnt <= '0;
            bit_cnt  <= (&bit_cnt) ? bit_cnt : bit_cnt + BIT_CNT_W'(1);
        end else begin
            edge_cnt <= edge_cnt + ONE;
        end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            s           <= 2'b11;
            sampled_bit <= 1'b1;
            sample_done <= 1'b0;
        end else begin
            sample_done <= samp_en & (edge_cnt == h_p1);
            if (samp_en && edge_cnt == h_m1) s[0] <= RX_IN;
            if (samp_en && edge_cnt == h) s[1] <= RX_IN;
            if (samp_en && edge_cnt == h_p1)
                sampled_bit <= (s[0] & s[1]) | (s[0] & RX_IN) | (s[1] & RX_IN);
        end
endmodule

// File: tb/tb_uart_rx_edge_bit_sampler.sv
// tb_uart_rx_edge_bit_sampler: per-scenario checks plus a scoreboard of expected recovered bits
module tb_uart_rx_edge_bit_sampler;
    logic clk = 1'b0, rst = 1'b0, RX_IN = 1'b1, cnt_enable = 1'b0, data_samp_en = 1'b0;
    logic [5:0] prescale = 6'd8;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic last_edge_flag, sample_done, sampled_bit;
    logic [11:0] obs;
    int errors = 0, checks = 0;
    bit exp_q[$];

    uart_rx_edge_bit_sampler #(.PRESCALE_W(6), .BIT_CNT_W(4)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .prescale(prescale),
        .cnt_enable(cnt_enable), .data_samp_en(data_samp_en),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .last_edge_flag(last_edge_flag),
        .sample_done(sample_done), .sampled_bit(sampled_bit)
    );

    always #5 clk = ~clk;
    assign obs = {edge_cnt, bit_cnt, last_edge_flag, sample_done};

    // every strobe pops one expected bit; stray strobes and wrong bits are failures
    always @(negedge clk)
        if (rst && sample_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe: unexpected sample_done at edge_cnt=%0d bit_cnt=%0d", edge_cnt, bit_cnt);
            end else begin
                automatic bit x = exp_q.pop_front();
                if (sampled_bit !== x) begin
                    errors++;
                    $display("FAIL strobe_bit: sampled_bit=%b want %b at bit_cnt=%0d", sampled_bit, x, bit_cnt);
                end
            end
        end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== 12'h000 || sampled_bit !== 1'b1) begin
            errors++;
            $display("FAIL reset: obs=%h sb=%b want 000 sb=1", obs, sampled_bit);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_p8();
        prescale = 6'd8; cnt_enable = 1'b0; data_samp_en = 1'b1; RX_IN = 1'b0;
        @(negedge clk);
        cnt_enable = 1'b1;
        for (int i = 0; i < 24; i++) begin
            automatic int e = i % 8;
            automatic logic [11:0] x = {6'(e), 4'(i / 8), e == 7, e == 6};
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL p8 cyc %0d: obs=%h want %h", i, obs, x);
            end
            if (e == 5) exp_q.push_back(1'b0);
            @(negedge clk);
        end
    endtask

    task automatic test_p16();
        logic [2:0] pat [2] = '{3'b101, 3'b100};
        bit maj [2] = '{1'b1, 1'b0};
        prescale = 6'd16; cnt_enable = 1'b0; data_samp_en = 1'b1;
        @(negedge clk);
        cnt_enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            automatic int e = i % 16;
            automatic int b = i / 16;
            automatic logic [11:0] x = {6'(e), 4'(b), e == 15, e == 10};
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL p16 cyc %0d: obs=%h want %h", i, obs, x);
            end
            RX_IN = (e >= 7 && e <= 9) ? pat[b][9 - e] : ~maj[b];
            if (e == 9) exp_q.push_back(maj[b]);
            @(negedge clk);
        end
    endtask

    task automatic test_abort();
        prescale = 6'd16; cnt_enable = 1'b0; data_samp_en = 1'b1; RX_IN = 1'b1;
        @(negedge clk);
        cnt_enable = 1'b1;
        for (int i = 0; i < 53; i++) begin
            if (i % 16 == 9) exp_q.push_back(1'b1);
            @(negedge clk);
        end
        checks++;
        if (obs !== {6'd5, 4'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_pre: obs=%h want %h", obs, {6'd5, 4'd3, 2'b00});
        end
        RX_IN = 1'b0; cnt_enable = 1'b0;
        @(negedge clk);
        checks++;
        if (obs !== 12'h000 || sampled_bit !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: obs=%h sb=%b want 000 sb=1", obs, sampled_bit);
        end
        cnt_enable = 1'b1;
        repeat (9) @(negedge clk);
        cnt_enable = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 12'h000 || sampled_bit !== 1'b1) begin
            errors++;
            $display("FAIL abort_pending: obs=%h sb=%b want 000 sb=1", obs, sampled_bit);
        end
    endtask

    task automatic test_no_samp();
        prescale = 6'd16; cnt_enable = 1'b0; data_samp_en = 1'b0; RX_IN = 1'b0;
        @(negedge clk);
        cnt_enable = 1'b1;
        for (int i = 0; i < 48; i++) begin
            automatic int e = i % 16;
            automatic int b = i / 16;
            automatic logic [11:0] x = {6'(e), 4'(b), e == 15, b == 2 && e == 10};
            checks++;
            if (obs !== x || sampled_bit !== 1'b1) begin
                errors++;
                $display("FAIL no_samp cyc %0d: obs=%h sb=%b want %h sb=1", i, obs, sampled_bit, x);
            end
            data_samp_en = (b == 2) || (b == 1 && (e == 7 || e == 8));
            RX_IN = (b == 2) && (e == 7 || e == 8);
            if (b == 2 && e == 9) exp_q.push_back(1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        prescale = 6'd16; cnt_enable = 1'b0; data_samp_en = 1'b1; RX_IN = 1'b0;
        @(negedge clk);
        cnt_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            automatic logic [11:0] x = {6'(i), 4'd0, i == 15, i == 10};
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL switch_p16 cyc %0d: obs=%h want %h", i, obs, x);
            end
            if (i == 1) prescale = 6'd8;
            if (i == 9) exp_q.push_back(1'b0);
            if (i == 15) cnt_enable = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (obs !== 12'h000) begin
            errors++;
            $display("FAIL gap: obs=%h want 000", obs);
        end
        cnt_enable = 1'b1; RX_IN = 1'b1;
        for (int i = 0; i < 16; i++) begin
            automatic int e = i % 8;
            automatic logic [11:0] x = {6'(e), 4'(i / 8), e == 7, e == 6};
            checks++;
            if (obs !== x) begin
                errors++;
                $display("FAIL switch_p8 cyc %0d: obs=%h want %h", i, obs, x);
            end
            if (e == 5) exp_q.push_back(1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_sat_reset();
        prescale = 6'd8; cnt_enable = 1'b0; data_samp_en = 1'b1; RX_IN = 1'b0;
        @(negedge clk);
        cnt_enable = 1'b1;
        for (int i = 0; i < 163; i++) begin
            automatic int e = i % 8;
            automatic int b = (i / 8 > 15) ? 15 : i / 8;
            if (e == 0) begin
                checks++;
                if (obs !== {6'd0, 4'(b), 2'b00}) begin
                    errors++;
                    $display("FAIL sat cyc %0d: obs=%h want %h", i, obs, {6'd0, 4'(b), 2'b00});
                end
            end
            if (e == 5) exp_q.push_back(1'b0);
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== 12'h000 || sampled_bit !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: obs=%h sb=%b want 000 sb=1", obs, sampled_bit);
        end
        cnt_enable = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs !== 12'h000 || sampled_bit !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: obs=%h sb=%b want 000 sb=1", obs, sampled_bit);
        end
    endtask

    initial begin
        test_reset();
        test_p8();
        test_p16();
        test_abort();
        test_no_samp();
        test_back_to_back();
        test_sat_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: %0d expected bits never strobed, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
